// File: rtl/seq_shift_left.sv
// Multi-cycle shift-left / rotate-left unit, one bit position per clock.
// Start/busy/done handshake; carry reports the last bit shifted out.
module seq_shift_left #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CNT_W = AMT_W + 1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               rot_r, rot_s;
  logic [WIDTH-1:0]   result_s;
  logic               carry_s;
  logic [AMT_W-1:0]   amt_s;
  logic [CNT_W-1:0]   k_s;
  logic               zero_s;
  logic [WIDTH-1:0]   shifted_s;
  logic               b_unused_s;

  // Rotations wrap modulo WIDTH; logical shifts keep the raw amount.
  function automatic logic [CNT_W-1:0] eff_count(input logic [AMT_W-1:0] amt,
                                                 input logic rot_i);
    logic [CNT_W-1:0] ext;
    ext = {1'b0, amt};
    if (rot_i) begin
      eff_count = ext % WIDTH_C;
    end else begin
      eff_count = ext;
    end
  endfunction

  // A logical shift by WIDTH or more clears the operand outright.
  function automatic logic is_fast_zero(input logic [AMT_W-1:0] amt,
                                        input logic rot_i);
    is_fast_zero = !rot_i && ({1'b0, amt} >= WIDTH_C);
  endfunction

  assign b_unused_s = ^b[WIDTH-1:AMT_W];

  // Next-state, working register and result/carry update logic.
  always_comb begin
    state_s   = state_r;
    work_s    = work_r;
    count_s   = count_r;
    rot_s     = rot_r;
    result_s  = result;
    carry_s   = carry;
    amt_s     = b[AMT_W-1:0];
    k_s       = eff_count(amt_s, rot);
    zero_s    = is_fast_zero(amt_s, rot);
    shifted_s = {work_r[WIDTH-2:0], rot_r & work_r[WIDTH-1]};
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          if (zero_s) begin
            state_s  = DONE;
            result_s = {WIDTH{1'b0}};
            carry_s  = 1'b0;
          end else if (k_s == {CNT_W{1'b0}}) begin
            state_s  = DONE;
            result_s = a;
            carry_s  = 1'b0;
          end else begin
            state_s  = SHIFT;
            count_s  = k_s;
            work_s   = a;
            rot_s    = rot;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s  = shifted_s;
        count_s = count_r - CNT_W'(1);
        // The final step publishes the result; earlier steps leave it untouched.
        if (count_r == CNT_W'(1)) begin
          state_s  = DONE;
          result_s = shifted_s;
          carry_s  = work_r[WIDTH-1];
        end else begin
          state_s  = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, working registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      rot_r   <= 1'b0;
      result  <= {WIDTH{1'b0}};
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      count_r <= count_s;
      rot_r   <= rot_s;
      result  <= result_s;
      carry   <= carry_s;
      busy    <= (state_s == SHIFT);
      done    <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_seq_shift_left.sv
// Self-checking bench for seq_shift_left: directed plan steps plus random
// operations checked against an arithmetic reference model.
module tb_seq_shift_left;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       rot;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prev_res = 8'h00;

  always #5 clk = ~clk;

  seq_shift_left #(.WIDTH(8), .AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .rot    (rot),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shift/rotate as plain integer arithmetic.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic mr,
                                output int k, output logic [7:0] res, output logic c);
    int va;
    int amt;
    va  = int'(ma);
    amt = int'(mb[3:0]);
    if (mr) begin
      k   = amt % 8;
      res = 8'((va << k) | (va >> (8 - k)));
      c   = (k == 0) ? 1'b0 : res[0];
    end else if (amt >= 8) begin
      k   = 0;
      res = 8'h00;
      c   = 1'b0;
    end else begin
      k   = amt;
      res = 8'(va << k);
      c   = (k == 0) ? 1'b0 : 1'((va >> (8 - k)) & 1);
    end
  endfunction

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tr);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    rot   = tr;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    rot   = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tr, input int busy0);
    int         k;
    logic [7:0] er;
    logic       ec;
    int         nb;
    bit         held;
    bit         seen;
    model(ta, tb_v, tr, k, er, ec);
    nb   = busy0;
    held = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) nb++;
      if (result !== prev_res) held = 1'b0;
      @(posedge clk);
      #1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(k));
    check({tag, "_result_held"}, 32'(held), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    prev_res = er;
  endtask

  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input logic tr);
    @(negedge clk);
    launch(ta, tb_v, tr);
    finish_op(tag, ta, tb_v, tr, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    rot   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op("sll1", 8'h81, 8'h01, 1'b0);
    op("rol7", 8'h81, 8'h07, 1'b1);
    op("sll_fastzero", 8'hFF, 8'h0A, 1'b0);
    op("sll0", 8'h5A, 8'h00, 1'b0);
    op("rol9", 8'h81, 8'h09, 1'b1);
    op("rol8", 8'h3C, 8'h08, 1'b1);

    // Start pulse while busy must be ignored, then a back-to-back op from DONE.
    @(negedge clk);
    launch(8'h01, 8'h05, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    rot   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    finish_op("ign_sll5", 8'h01, 8'h05, 1'b0, 1);
    launch(8'h81, 8'h02, 1'b1);
    finish_op("b2b_rol2", 8'h81, 8'h02, 1'b1, 0);
    @(posedge clk);
    #1;
    check("b2b_done_fall", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    launch(8'hA5, 8'h06, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = 8'h00;
    op("post_rst_sll3", 8'h01, 8'h03, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_left.md
Name: seq_shift_left

Overview:
- Multi-cycle left-shift unit for the ALU shift path; complements the existing combinational arithmetic right shift.
- Performs logical shift left (SLL) or rotate left (ROL) of an 8-bit operand, one bit position per clock.
- Start/busy/done handshake lets the control FSM stall on variable-latency shifts.
- Reports the last bit shifted out as a carry flag.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 4, width of the shift-amount field taken from b[AMT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy==0.
- a  input  WIDTH  operand to shift, sampled on accept.
- b  input  WIDTH  shift amount; only b[3:0] used, sampled on accept.
- rot  input  1  0 = logical shift left (zero fill), 1 = rotate left; sampled on accept.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse when result/carry become valid.
- result  output  WIDTH  shifted value; held until the next done.
- carry  output  1  last bit shifted/rotated out; held with result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry=0; internal working register and counter cleared.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 sampled at a rising edge while state is IDLE or DONE (busy==0); latch a, amt=b[3:0], rot.
- Effective count k:
  - rot=1: k=amt mod 8.
  - rot=0, amt<=7: k=amt.
  - rot=0, amt>=8: fast-zero case.
- Fast path (k==0, or fast-zero case): go directly to DONE on the accept edge.
  - k==0: result=a, carry=0.
  - fast-zero: result=0, carry=0.
- Shift path (k>=1): go to SHIFT on the accept edge with count=k and work=a.
  - Each SHIFT cycle, SLL: carry_w=work[7], work={work[6:0],1'b0}.
  - Each SHIFT cycle, ROL: carry_w=work[7], work={work[6:0],work[7]}.
  - count decrements by 1 each cycle; the cycle in which count goes 1->0 transitions to DONE and loads result=work_next, carry=carry_w.
- Latency: accept on edge N gives done=1 in the cycle after edge N+k (fast path: after edge N). busy=1 for exactly k cycles.
- DONE: done=1 for exactly one cycle, then IDLE, unless start=1 in that cycle, which accepts a new request (back-to-back; done still pulses once).
- result/carry update only on entry to DONE and are stable at all other times, including during SHIFT.
- start while busy=1: ignored; no state, operand or output change.
- a/b/rot changes after accept: no effect on the operation in flight.
- Reset mid-SHIFT: aborts immediately; no done pulse; outputs go to reset values.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- Reset, then a=0x81, b=0x01, rot=0, start pulse -> busy=1 for 1 cycle; done pulse with result=0x02, carry=1.
- a=0x81, b=0x07, rot=1 -> busy for 7 cycles; done with result=0xC0, carry=0; result holds prior value during busy.
- a=0xFF, b=0x0A, rot=0 -> fast path, no busy; done the cycle after accept with result=0x00, carry=0. a=0x5A, b=0x00 -> result=0x5A, carry=0, same latency.
- a=0x81, b=0x09, rot=1 -> k=1, result=0x03, carry=1. Then a=0x3C, b=0x08, rot=1 -> fast path, result=0x3C, carry=0.
- During a k=5 SLL of 0x01, pulse start with a=0xFF, b=0x01 -> ignored; done once with result=0x20, carry=0. Assert start in the DONE cycle -> second op accepted, second done follows correctly.
- Assert rst_n=0 mid-SHIFT (k=6) -> busy/done/result/carry=0 immediately, no done pulse. After release, a fresh a=0x01, b=0x03, rot=0 -> result=0x08.
